simon_key_rd_arbiter: RTL and testbench



---
 rtl/simon_key_rd_arbiter_pkg.sv | 13 +
 rtl/simon_key_rd_arbiter_rr.sv | 43 ++++
 rtl/simon_key_rd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_simon_key_rd_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/simon_key_rd_arbiter_pkg.sv
// Shared constants and the in-flight tag type for the Simon key-memory read path.
package simon_pkg;
  localparam int SIMON_ROUNDS     = 72;
  localparam int SIMON_KEY_W      = 64;
  localparam int SIMON_KEY_ADDR_W = 9;
  localparam int SIMON_KEY_RD_LAT = 2;

  typedef struct packed {
    logic       vld;
    logic [2:0] lane;
    logic       stale;
  } key_tag_t;
endpackage

// File: rtl/simon_key_rd_arbiter_rr.sv
// Generic round-robin arbiter: grants the first requester at or after the
// pointer and advances the pointer past the winner.
module simon_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan from farthest to nearest so the nearest match is written last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[IDX_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o)
      ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/simon_key_rd_arbiter.sv
// Shares the round-key memory read port among NUM_REQ cipher lanes and routes
// each returned subkey back to its requester. Define SIMON_KEY_ARB_ADDR_CHECK_EN
// to turn out-of-range addresses into error responses instead of reads.
module simon_key_rd_arbiter
  import simon_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int RD_LAT     = SIMON_KEY_RD_LAT,
  parameter int NUM_ROUNDS = SIMON_ROUNDS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                key_compute_start,
  input  logic                                key_mem_full,
  output logic                                keys_valid,
  input  logic [NUM_REQ-1:0]                  req_vld,
  input  logic [NUM_REQ*SIMON_KEY_ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]                  req_rdy,
  output logic [NUM_REQ-1:0]                  rsp_vld,
  output logic [SIMON_KEY_W-1:0]              rsp_data,
  output logic                                rsp_err,
  output logic                                key_rd_en,
  output logic [SIMON_KEY_ADDR_W-1:0]         key_addr,
  input  logic [SIMON_KEY_W-1:0]              key_data,
  input  logic                                key_data_vld
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = SIMON_KEY_ADDR_W;

  if (NUM_REQ < 2 || NUM_REQ > 8 || RD_LAT < 1 || NUM_ROUNDS > (1 << AW)) begin : g_bad_cfg
    $error("simon_key_rd_arbiter: unsupported parameter set");
  end

  logic                   keys_valid_q;
  logic [NUM_REQ-1:0]     req_masked, gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   hs;
  logic [AW-1:0]          gnt_addr;
  logic                   addr_ok;

  logic                   key_rd_en_q;
  logic [AW-1:0]          key_addr_q;
  logic                   iss_vld_q, iss_dmy_q;
  logic [2:0]             iss_lane_q;

  key_tag_t               tag_q [RD_LAT];
  logic [RD_LAT-1:0]      dmy_q;
  key_tag_t               head;
  logic                   head_dmy;

  logic                   fire_real, fire_dmy, fire;
  logic [NUM_REQ-1:0]     rsp_vld_d, rsp_vld_q;
  logic [SIMON_KEY_W-1:0] rsp_data_q;
  logic                   rsp_err_q;
  logic [RD_LAT-1:0]      rst_hist_q;

  // Key validity: restart beats completion when both arrive together.
  always_ff @(posedge clk) begin
    if (rst)                    keys_valid_q <= 1'b0;
    else if (key_compute_start) keys_valid_q <= 1'b0;
    else if (key_mem_full)      keys_valid_q <= 1'b1;
  end

  assign req_masked = req_vld & {NUM_REQ{keys_valid_q & ~key_compute_start}};

  simon_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_masked),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (hs)
  );

  assign gnt_addr = req_addr[gnt_idx*AW +: AW];

`ifdef SIMON_KEY_ARB_ADDR_CHECK_EN
  assign addr_ok = (gnt_addr < AW'(NUM_ROUNDS));
`else
  assign addr_ok = 1'b1;
`endif

  // Issue stage: one registered read per handshake; rejected addresses become dummies.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_rd_en_q <= 1'b0;
      key_addr_q  <= '0;
      iss_vld_q   <= 1'b0;
      iss_dmy_q   <= 1'b0;
      iss_lane_q  <= '0;
    end else begin
      key_rd_en_q <= hs & addr_ok;
      iss_vld_q   <= hs;
      iss_dmy_q   <= hs & ~addr_ok;
      if (hs) begin
        iss_lane_q <= 3'(gnt_idx);
        if (addr_ok) key_addr_q <= gnt_addr;
      end
    end
  end

  // Tags enter while the read is on the port, so the last stage lines up with returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      dmy_q <= '0;
    end else begin
      tag_q[0] <= '{vld: iss_vld_q, lane: iss_lane_q, stale: key_compute_start};
      dmy_q[0] <= iss_dmy_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= '{vld:   tag_q[i-1].vld,
                      lane:  tag_q[i-1].lane,
                      stale: tag_q[i-1].stale | key_compute_start};
        dmy_q[i] <= dmy_q[i-1];
      end
    end
  end

  assign head      = tag_q[RD_LAT-1];
  assign head_dmy  = dmy_q[RD_LAT-1];
  assign fire_real = head.vld & ~head_dmy & key_data_vld;
  assign fire_dmy  = head.vld & head_dmy;
  assign fire      = fire_real | fire_dmy;

  always_comb begin
    rsp_vld_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_vld_d[i] = fire && (head.lane == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= fire & (head.stale | head_dmy | key_compute_start);
      if (fire_dmy)       rsp_data_q <= '0;
      else if (fire_real) rsp_data_q <= key_data;
    end
  end

  // Reads launched just before a reset still return; don't flag those as protocol errors.
  always_ff @(posedge clk) begin
    rst_hist_q <= (rst_hist_q << 1) | RD_LAT'(rst);
  end

  always_ff @(posedge clk) begin
    if (!rst && rst_hist_q == '0)
      assert (key_data_vld == (head.vld && !head_dmy));
  end

  assign keys_valid = keys_valid_q;
  assign req_rdy    = gnt;
  assign key_rd_en  = key_rd_en_q;
  assign key_addr   = key_addr_q;
  assign rsp_vld    = rsp_vld_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_simon_key_rd_arbiter.sv
// Directed bench for simon_key_rd_arbiter with a 2-cycle key memory model.
module tb_simon_key_rd_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        key_compute_start, key_mem_full, keys_valid;
  logic [3:0]  req_vld, req_rdy, rsp_vld;
  logic [35:0] req_addr;
  logic [63:0] rsp_data, key_data;
  logic        rsp_err, key_rd_en, key_data_vld;
  logic [8:0]  key_addr;

  int total = 0;
  int bad   = 0;

  simon_key_rd_arbiter #(.NUM_REQ(4), .RD_LAT(2), .NUM_ROUNDS(72)) dut (
    .clk(clk), .rst(rst),
    .key_compute_start(key_compute_start), .key_mem_full(key_mem_full),
    .keys_valid(keys_valid),
    .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .key_rd_en(key_rd_en), .key_addr(key_addr),
    .key_data(key_data), .key_data_vld(key_data_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] memv(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'h5A00_0000 + 32'(a)};
  endfunction

  // Key memory: data valid two cycles after the read strobe.
  logic [1:0] rd_pipe;
  logic [8:0] ad_pipe [2];
  always @(posedge clk) begin
    rd_pipe    <= {rd_pipe[0], key_rd_en};
    ad_pipe[0] <= key_addr;
    ad_pipe[1] <= ad_pipe[0];
  end
  assign key_data_vld = rd_pipe[1];
  assign key_data     = rd_pipe[1] ? memv(int'(ad_pipe[1])) : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int lane, input int a);
    req_addr[lane*9 +: 9] = 9'(a);
  endtask

  task automatic chk_rst_state(input string tag);
    chk({tag, ".keys_valid"}, 64'(keys_valid), 64'd0);
    chk({tag, ".req_rdy"},    64'(req_rdy),    64'd0);
    chk({tag, ".rsp_vld"},    64'(rsp_vld),    64'd0);
    chk({tag, ".rsp_data"},   rsp_data,        64'd0);
    chk({tag, ".rsp_err"},    64'(rsp_err),    64'd0);
    chk({tag, ".key_rd_en"},  64'(key_rd_en),  64'd0);
    chk({tag, ".key_addr"},   64'(key_addr),   64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rsp;
    rst = 1'b1; key_compute_start = 1'b0; key_mem_full = 1'b0;
    req_vld = 4'b0; req_addr = '0;
    rd_pipe = '0;
    repeat (3) step();
    req_vld = 4'b0010; set_addr(1, 5); #1;
    chk_rst_state("reset");
    rst = 1'b0;

    // Requests before the schedule is complete see no grant.
    step(); #1;
    chk("pre_full.req_rdy", 64'(req_rdy), 64'd0);
    chk("pre_full.key_rd_en", 64'(key_rd_en), 64'd0);
    key_mem_full = 1'b1; #1;
    chk("full_pulse.req_rdy", 64'(req_rdy), 64'd0);
    step(); key_mem_full = 1'b0; #1;
    chk("post_full.keys_valid", 64'(keys_valid), 64'd1);
    chk("post_full.req_rdy", 64'(req_rdy), 64'b0010);
    step(); req_vld = 4'b0; #1;
    chk("t1.key_rd_en", 64'(key_rd_en), 64'd1);
    chk("t1.key_addr", 64'(key_addr), 64'd5);
    step(); #1;
    chk("t1.key_rd_en_off", 64'(key_rd_en), 64'd0);
    step(); #1;
    chk("t1.rsp_early", 64'(rsp_vld), 64'd0);
    step(); #1;
    chk("t1.rsp_vld", 64'(rsp_vld), 64'b0010);
    chk("t1.rsp_data", rsp_data, memv(5));
    chk("t1.rsp_err", 64'(rsp_err), 64'd0);
    step(); #1;
    chk("t1.rsp_vld_off", 64'(rsp_vld), 64'd0);
    chk("t1.rsp_data_hold", rsp_data, memv(5));

    // Pointer is at 2: a lone lane-3 read returns it to 0, then all lanes stream.
    req_vld = 4'b1000; set_addr(3, 7); #1;
    chk("lane3.req_rdy", 64'(req_rdy), 64'b1000);
    set_addr(0, 0); set_addr(1, 1); set_addr(2, 2);
    for (int k = 0; k < 13; k++) begin
      step();
      if (k == 0) set_addr(3, 3);
      req_vld = (k < 8) ? 4'b1111 : 4'b0000; #1;
      chk($sformatf("rr%0d.req_rdy", k), 64'(req_rdy),
          (k < 8) ? 64'(4'b0001 << (k % 4)) : 64'd0);
      chk($sformatf("rr%0d.key_rd_en", k), 64'(key_rd_en), (k <= 8) ? 64'd1 : 64'd0);
      if (k == 0)      chk("rr0.key_addr", 64'(key_addr), 64'd7);
      else if (k <= 8) chk($sformatf("rr%0d.key_addr", k), 64'(key_addr), 64'((k - 1) % 4));
      if (k < 3)       exp_rsp = 4'b0000;
      else if (k == 3) exp_rsp = 4'b1000;
      else if (k < 12) exp_rsp = 4'b0001 << ((k - 4) % 4);
      else             exp_rsp = 4'b0000;
      chk($sformatf("rr%0d.rsp_vld", k), 64'(rsp_vld), 64'(exp_rsp));
      if (k == 3) chk("rr3.rsp_data", rsp_data, memv(7));
      else if (k >= 4 && k < 12)
        chk($sformatf("rr%0d.rsp_data", k), rsp_data, memv((k - 4) % 4));
    end

    // Two reads in flight, then a key restart.
    req_vld = 4'b0101; set_addr(0, 10); set_addr(2, 20); #1;
    chk("rs.a.req_rdy", 64'(req_rdy), 64'b0001);
    step(); #1;
    chk("rs.a1.req_rdy", 64'(req_rdy), 64'b0100);
    step(); key_compute_start = 1'b1; #1;
    chk("rs.a2.req_rdy", 64'(req_rdy), 64'd0);
    chk("rs.a2.key_addr", 64'(key_addr), 64'd20);
    step(); key_compute_start = 1'b0; #1;
    chk("rs.a3.keys_valid", 64'(keys_valid), 64'd0);
    chk("rs.a3.req_rdy", 64'(req_rdy), 64'd0);
    step(); #1;
    chk("rs.a4.rsp_vld", 64'(rsp_vld), 64'b0001);
    chk("rs.a4.rsp_err", 64'(rsp_err), 64'd1);
    chk("rs.a4.rsp_data", rsp_data, memv(10));
    step(); #1;
    chk("rs.a5.rsp_vld", 64'(rsp_vld), 64'b0100);
    chk("rs.a5.rsp_err", 64'(rsp_err), 64'd1);
    chk("rs.a5.rsp_data", rsp_data, memv(20));
    step(); req_vld = 4'b0; #1;
    chk("rs.a6.rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rs.a6.key_rd_en", 64'(key_rd_en), 64'd0);

    // Out-of-range address from lane 2 (pointer is at 3, only lane 2 asks).
    key_mem_full = 1'b1;
    step(); key_mem_full = 1'b0;
    req_vld = 4'b0100; set_addr(2, 72); #1;
    chk("oor.req_rdy", 64'(req_rdy), 64'b0100);
    step(); req_vld = 4'b0; #1;
`ifdef SIMON_KEY_ARB_ADDR_CHECK_EN
    chk("oor.key_rd_en", 64'(key_rd_en), 64'd0);
`else
    chk("oor.key_rd_en", 64'(key_rd_en), 64'd1);
    chk("oor.key_addr", 64'(key_addr), 64'd72);
`endif
    step(); step(); step(); #1;
    chk("oor.rsp_vld", 64'(rsp_vld), 64'b0100);
`ifdef SIMON_KEY_ARB_ADDR_CHECK_EN
    chk("oor.rsp_err", 64'(rsp_err), 64'd1);
    chk("oor.rsp_data", rsp_data, 64'd0);
`else
    chk("oor.rsp_err", 64'(rsp_err), 64'd0);
    chk("oor.rsp_data", rsp_data, memv(72));
`endif

    // Reset with two reads in flight: nothing comes back afterwards.
    step();
    req_vld = 4'b0011; set_addr(0, 30); set_addr(1, 31); #1;
    chk("rr_rst.c.req_rdy", 64'(req_rdy), 64'b0001);
    step(); #1;
    chk("rr_rst.c1.req_rdy", 64'(req_rdy), 64'b0010);
    step(); req_vld = 4'b0; rst = 1'b1; #1;
    chk("rr_rst.c2.key_rd_en", 64'(key_rd_en), 64'd1);
    step(); rst = 1'b0; #1;
    chk_rst_state("mid_rst");
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk($sformatf("mid_rst%0d.rsp_vld", k), 64'(rsp_vld), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
